ram_bist_ctrl: RTL and testbench



---
 rtl/ram_bist_ctrl.sv | 145 ++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_ctrl.sv
// rtl/ram_bist_ctrl.sv - march self-test controller driving a 4x4 RAM array
// Optional: define RAM_BIST_STOP_ON_FAIL_EN to abort the test at the first mismatching read.
module ram_bist_ctrl #(
  parameter int unsigned ACC_CYCLES = 2,
  parameter logic [3:0]  PATTERN    = 4'b1010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [1:0] fail_addr,
  output logic [3:0] fail_data,
  output logic       ram_cs_n,
  output logic       ram_rw,
  output logic [1:0] ram_addr,
  output logic [3:0] ram_wdata,
  input  logic [3:0] ram_rdata
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, RECOVER, FINISH} state_t;

`ifdef RAM_BIST_STOP_ON_FAIL_EN
  localparam logic STOP_ON_FAIL = 1'b1;
`else
  localparam logic STOP_ON_FAIL = 1'b0;
`endif

  localparam logic [2:0] STROBE_LAST = 3'(ACC_CYCLES - 1);
  localparam logic [3:0] LAST_ACCESS = 4'd15;

  state_t     state;
  logic [3:0] acc_idx;
  logic [2:0] strobe_cnt;
  logic       abort;

  logic [3:0] next_idx;
  logic [1:0] next_addr;
  logic       next_rw;
  logic [3:0] next_wdata;
  logic [3:0] expect_data;
  logic       mismatch;

  // acc_idx = {pass, step}; passes 2 and 3 walk downwards with complemented data,
  // odd passes are reads.
  always_comb begin
    next_idx    = acc_idx + 4'd1;
    next_addr   = next_idx[3] ? ~next_idx[1:0] : next_idx[1:0];
    next_rw     = ~next_idx[2];
    next_wdata  = next_rw ? (next_idx[3] ? ~PATTERN : PATTERN) : 4'h0;
    expect_data = acc_idx[3] ? ~PATTERN : PATTERN;
    mismatch    = !ram_rw && (ram_rdata != expect_data);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      acc_idx    <= '0;
      strobe_cnt <= '0;
      abort      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_addr  <= '0;
      fail_data  <= '0;
      ram_cs_n   <= 1'b1;
      ram_rw     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= SETUP;
            acc_idx   <= '0;
            abort     <= 1'b0;
            busy      <= 1'b1;
            pass      <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            ram_cs_n  <= 1'b1;
            ram_rw    <= 1'b1;
            ram_addr  <= 2'd0;
            ram_wdata <= PATTERN;
          end
        end

        SETUP: begin
          ram_cs_n   <= 1'b0;
          strobe_cnt <= '0;
          state      <= STROBE;
        end

        STROBE: begin
          if (strobe_cnt == STROBE_LAST) begin
            ram_cs_n <= 1'b1;
            state    <= RECOVER;
            // Read data is captured on the edge that closes the strobe window.
            if (mismatch) begin
              err_count <= err_count + 4'd1;
              if (err_count == 4'd0) begin
                fail_addr <= ram_addr;
                fail_data <= ram_rdata;
              end
              abort <= STOP_ON_FAIL;
            end
          end else begin
            strobe_cnt <= strobe_cnt + 3'd1;
          end
        end

        RECOVER: begin
          if (abort || acc_idx == LAST_ACCESS) begin
            state     <= FINISH;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= (err_count == 4'd0);
            ram_rw    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
          end else begin
            state     <= SETUP;
            acc_idx   <= next_idx;
            ram_rw    <= next_rw;
            ram_addr  <= next_addr;
            ram_wdata <= next_wdata;
          end
        end

        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb/tb_ram_bist_ctrl.sv - self-checking bench for ram_bist_ctrl with a faultable RAM model
module tb_ram_bist_ctrl;

  localparam int         ACC = 2;
  localparam logic [3:0] PAT = 4'b1010;

  logic       clk;
  logic       reset;
  logic       start;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [1:0] fail_addr;
  logic [3:0] fail_data;
  logic       ram_cs_n, ram_rw;
  logic [1:0] ram_addr;
  logic [3:0] ram_wdata;
  logic [3:0] ram_rdata;

  ram_bist_ctrl #(.ACC_CYCLES(ACC), .PATTERN(PAT)) dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_addr(fail_addr), .fail_data(fail_data),
    .ram_cs_n(ram_cs_n), .ram_rw(ram_rw), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with per-bit stuck-at faults: read = (stored & and_m) | or_m, word w at bits [4w+3:4w].
  logic [3:0]  mem [4];
  logic [15:0] and_m, or_m;

  always @(posedge clk)
    if (!ram_cs_n && ram_rw) mem[ram_addr] <= ram_wdata;

  always_comb
    ram_rdata = (mem[ram_addr] & and_m[{ram_addr, 2'b00} +: 4]) | or_m[{ram_addr, 2'b00} +: 4];

  // Access log and pin-stability monitor.
  logic [6:0] got_q [$];
  logic [6:0] exp_q [$];
  logic       prev_cs_n = 1'b1;
  logic [6:0] prev_sig  = '0;
  int         viol;

  always @(negedge clk) begin
    if (!ram_cs_n) begin
      if (prev_cs_n) got_q.push_back({ram_rw, ram_addr, ram_wdata});
      if ({ram_rw, ram_addr, ram_wdata} != prev_sig) viol++;
    end
    prev_cs_n = ram_cs_n;
    prev_sig  = {ram_rw, ram_addr, ram_wdata};
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  function automatic int outs();
    return int'({busy, done, pass, err_count, fail_addr, fail_data,
                 ram_cs_n, ram_rw, ram_addr, ram_wdata});
  endfunction
  localparam int RESET_OUTS = 128;  // only ram_cs_n high

  // Reference: walk the march algorithm over an array memory.
  int m_err, m_fa, m_fd, m_pass, m_n;

  task automatic model(input logic [15:0] am, input logic [15:0] om);
    logic [3:0] mm [4];
    logic [3:0] d, rd;
    logic [1:0] a;
    bit stop;
    exp_q.delete();
    m_err = 0; m_fa = 0; m_fd = 0; m_n = 0; stop = 0;
    for (int p = 0; p < 4 && !stop; p++)
      for (int i = 0; i < 4 && !stop; i++) begin
        a = (p >= 2) ? 2'(3 - i) : 2'(i);
        d = (p >= 2) ? ~PAT : PAT;
        m_n++;
        if (p % 2 == 0) begin
          mm[a] = d;
          exp_q.push_back({1'b1, a, d});
        end else begin
          exp_q.push_back({1'b0, a, 4'h0});
          rd = (mm[a] & am[a*4 +: 4]) | om[a*4 +: 4];
          if (rd != d) begin
            if (m_err == 0) begin m_fa = a; m_fd = rd; end
            m_err++;
`ifdef RAM_BIST_STOP_ON_FAIL_EN
            stop = 1;
`endif
          end
        end
      end
    m_pass = (m_err == 0) ? 1 : 0;
  endtask

  task automatic wait_done(input bit inject, output int e);
    e = 0;
    while (!done && e < 400) begin
      @(posedge clk); #1;
      e++;
      start = (inject && !done) ? ($urandom_range(0, 4) == 0) : 1'b0;
    end
    start = 1'b0;
    check("done_seen", int'(done), 1);
  endtask

  int got_edges, got_err, got_fa, got_fd, got_pass;

  task automatic do_test(input logic [15:0] am, input logic [15:0] om, input bit inject);
    int bad;
    and_m = am;
    or_m  = om;
    model(am, om);
    got_q.delete();
    viol  = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    check("err_cleared", int'(err_count), 0);
    wait_done(inject, got_edges);
    got_err  = err_count;
    got_fa   = fail_addr;
    got_fd   = fail_data;
    got_pass = pass;
    check("busy_at_done", int'(busy), 0);
    check("done_cycle", got_edges + 1, m_n * (ACC + 2) + 1);
    check("access_count", got_q.size(), exp_q.size());
    bad = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] != exp_q[i]) bad++;
    check("access_order", bad, 0);
    check("pin_stability", viol, 0);
    @(posedge clk); #1;
    check("done_pulse", int'(done), 0);
    check("pass_held", int'(pass), m_pass);
  endtask

  typedef struct {
    logic [15:0] am;
    logic [15:0] om;
    int err;
    int fa;
    int fd;
    int pss;
    int nacc;
  } vec_t;

  vec_t        tbl [6];
  int          e;
  logic [15:0] r_am, r_om;

  initial begin
    tbl[0] = '{16'hFFFF, 16'h0000, 0, 0, 0,  1, 16};
`ifdef RAM_BIST_STOP_ON_FAIL_EN
    tbl[1] = '{16'hFFBF, 16'h0000, 1, 1, 1,  0, 15};
    tbl[2] = '{16'hF0FF, 16'h0000, 1, 2, 0,  0, 7};
    tbl[3] = '{16'hFFFF, 16'h0001, 1, 0, 11, 0, 5};
    tbl[4] = '{16'hFFFF, 16'hFFFF, 1, 0, 15, 0, 5};
    tbl[5] = '{16'h7FFF, 16'h0000, 1, 3, 2,  0, 8};
`else
    tbl[1] = '{16'hFFBF, 16'h0000, 1, 1, 1,  0, 16};
    tbl[2] = '{16'hF0FF, 16'h0000, 2, 2, 0,  0, 16};
    tbl[3] = '{16'hFFFF, 16'h0001, 1, 0, 11, 0, 16};
    tbl[4] = '{16'hFFFF, 16'hFFFF, 8, 0, 15, 0, 16};
    tbl[5] = '{16'h7FFF, 16'h0000, 1, 3, 2,  0, 16};
`endif

    reset = 1'b0;
    start = 1'b0;
    and_m = 16'hFFFF;
    or_m  = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset_values", outs(), RESET_OUTS);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 6; t++) begin
      do_test(tbl[t].am, tbl[t].om, 1'b0);
      check($sformatf("tbl%0d_done_cycle", t), got_edges + 1, tbl[t].nacc * (ACC + 2) + 1);
      check($sformatf("tbl%0d_err_count", t), got_err, tbl[t].err);
      check($sformatf("tbl%0d_fail_addr", t), got_fa, tbl[t].fa);
      check($sformatf("tbl%0d_fail_data", t), got_fd, tbl[t].fd);
      check($sformatf("tbl%0d_pass", t), got_pass, tbl[t].pss);
    end

    // start during busy and during FINISH is ignored; start the cycle after done restarts
    and_m = 16'hFFFF;
    or_m  = 16'h0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b1, e);
    check("busy_starts_ignored_cycle", e + 1, 65);
    start = 1'b1;
    @(posedge clk); #1;
    check("finish_start_ignored", int'(busy), 0);
    check("done_one_cycle", int'(done), 0);
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_busy", int'(busy), 1);
    check("restart_pass_clear", int'(pass), 0);
    wait_done(1'b0, e);
    check("restart_cycle", e + 1, 65);
    check("restart_pass", int'(pass), 1);
    @(posedge clk); #1;

    // asynchronous reset while the first P2 write is strobing
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (33) @(posedge clk);
    #1;
    check("p2_cs_low", int'(ram_cs_n), 0);
    check("p2_addr", int'(ram_addr), 3);
    check("p2_wdata", int'(ram_wdata), 5);
    #2 reset = 1'b0;
    #1;
    check("async_reset_values", outs(), RESET_OUTS);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", outs(), RESET_OUTS);
    do_test(16'hFFFF, 16'h0000, 1'b0);
    check("post_reset_cycle", got_edges + 1, 65);
    check("post_reset_pass", got_pass, 1);

    for (int r = 0; r < 20; r++) begin
      case ($urandom_range(0, 3))
        0: begin r_am = 16'hFFFF; r_om = 16'h0000; end
        1: begin r_am = ~(16'h1 << $urandom_range(0, 15)); r_om = 16'h0000; end
        2: begin r_am = 16'hFFFF; r_om = 16'h1 << $urandom_range(0, 15); end
        default: begin
          r_am = 16'($urandom) | 16'($urandom);
          r_om = 16'($urandom) & 16'($urandom) & 16'($urandom);
        end
      endcase
      do_test(r_am, r_om, 1'($urandom_range(0, 1)));
      check("rnd_err_count", got_err, m_err);
      check("rnd_fail_addr", got_fa, m_fa);
      check("rnd_fail_data", got_fd, m_fd);
      check("rnd_pass", got_pass, m_pass);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
